stack_unit: RTL
===============

# stack_unit

Memory-stage stack engine for the MIPS pipeline. It owns the stack pointer and performs all stack traffic against the 16-bit data memory: two-word PC pushes for `call`/`int`, two-word PC pops for `ret`, and single-word `push`/`pop`. It sits directly downstream of the memory-stage control; its `busy` output stalls the pipeline for the duration of each multi-cycle access, and its restored PC feeds the fetch-stage PC mux.

## Interface
- `SP_RESET`, default 32'h0000_0FFF: SP value after reset. This is the top-of-stack word address.
- `STACK_LIMIT`, default 32'h0000_0800: lowest legal stack word address. Used only with the guard feature.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `int`, `ret`, `call`, `push`, `pop` in 1 each: stack requests, sampled only in IDLE.
- `pc_in` in 32: PC to save; captured when `call` or `int` is accepted.
- `reg_in` in 16: word to save; captured when `push` is accepted.
- `mem_rdata` in 16: data memory read data, valid one cycle after `mem_re`.
- `mem_addr` out 32: data memory word address.
- `mem_wdata` out 16: write data.
- `mem_we`, `mem_re` out 1: write and read strobes.
- `sp` out 32: current stack pointer.
- `pc_out` out 32, `pc_valid` out 1: restored return PC, with a one-cycle valid pulse.
- `reg_out` out 16, `reg_valid` out 1: popped word, with a one-cycle valid pulse.
- `busy` out 1: high whenever the state is not IDLE.
- `stack_err` out 1: one-cycle pulse on a rejected request.

## Operation
- Reset values: `sp`=SP_RESET, state IDLE; every other output is 0.
- Reset asserted mid-operation aborts the sequence immediately with no partial completion; `sp` returns to SP_RESET.
- The stack is empty-descending:
  - A push writes at `sp`, then decrements `sp`.
  - A pop increments `sp`, then reads at the new `sp`.
- Request priority when several are high in IDLE: int > ret > call > pop > push. Losing requests are dropped.
- Requests are ignored while `busy`; the pipeline holds them stalled.
- States: IDLE, PSH1, PSH2, POP1, POP2, POP3, PSHW, POPW1, POPW2.
- `call`/`int` → PSH1 → PSH2 → IDLE:
  - PSH1 writes `pc[31:16]` at `sp`; PSH2 writes `pc[15:0]` at `sp`.
  - `sp` decrements by 1 in each of the two states.
- `ret` → POP1 → POP2 → POP3 → IDLE:
  - POP1 reads `sp+1` (the low half); POP2 reads `sp+1` (the high half).
  - `sp` increments by 1 in each of POP1 and POP2.
  - The low half is captured from `mem_rdata` in POP2; the high half in POP3.
  - `pc_out` is registered at the end of POP3. `pc_valid` pulses in the following IDLE cycle.
- `push` → PSHW → IDLE: writes `reg_in` at `sp`, then decrements `sp`.
- `pop` → POPW1 → POPW2 → IDLE:
  - POPW1 reads `sp+1` and increments `sp`.
  - `reg_out` is registered from `mem_rdata` in POPW2. `reg_valid` pulses in the next IDLE cycle.
- `mem_addr`, `mem_wdata`, `mem_we` and `mem_re` are combinational from state, `sp` and the captured data. They are 0 in IDLE and in POP3/POPW2.
- Arithmetic: `sp` is 32-bit modulo 2^32; `sp+1` is computed in 32 bits.
- `pc_out` and `reg_out` hold their values until the next pop of the same kind.

## Timing
- Request accepted at edge t0; the first memory cycle is t0+1.
- PC push: memory cycles t0+1 and t0+2; `busy` high for 2 cycles.
- PC pop: `busy` high t0+1 to t0+3; `pc_valid` at t0+4.
- Word push: `busy` high for 1 cycle.
- Word pop: `busy` high for 2 cycles; `reg_valid` at t0+3.
- A new request may be accepted in the same cycle that `pc_valid` or `reg_valid` is high.

## Configuration
- `STACK_GUARD_EN` defined:
  - A PC push is rejected if `sp-1 < STACK_LIMIT`.
  - A word push is rejected if `sp < STACK_LIMIT`.
  - A PC pop is rejected if `sp+2 > SP_RESET`.
  - A word pop is rejected if `sp+1 > SP_RESET`.
  - On rejection: stay in IDLE, no memory access, `sp` unchanged, `stack_err` pulses 1 cycle at t0+1.
- `STACK_GUARD_EN` undefined: no checks are made, `sp` wraps freely, and `stack_err` is tied 0.

## Test plan
- Reset, then `call` with `pc_in`=32'h1234_5678 → writes 16'h1234@0FFF, then 16'h5678@0FFE; `sp`=0FFD; `busy` high for 2 cycles.
- Then `ret` → reads at 0FFE and 0FFF; `pc_out`=32'h1234_5678, `pc_valid` at t0+4; `sp`=0FFF.
- `push` with `reg_in`=16'hBEEF, then `pop` → `reg_out`=16'hBEEF, `reg_valid` at t0+3, `sp` restored to 0FFF.
- `int` and `push` asserted together in IDLE → PC push only, no word write. Requests raised while `busy` are ignored.
- Reset asserted during POP2 → all outputs 0 and `sp`=0FFF immediately; no `pc_valid`.
- With `STACK_GUARD_EN`: `ret` at reset → `stack_err` pulse, no `mem_re`, `sp` stays 0FFF. Without the macro, the same `ret` gives `sp`=1001 and `stack_err`=0.

Source files
------------

// File: rtl/stack_unit.sv
// Memory-stage stack engine: SP ownership, two-word PC push/pop, single-word push/pop.
// Optional overflow/underflow guard enabled by defining STACK_GUARD_EN.
module stack_unit #(
   parameter logic [31:0] SP_RESET    = 32'h0000_0FFF,
   parameter logic [31:0] STACK_LIMIT = 32'h0000_0800
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        intr,
   input  logic        ret,
   input  logic        call,
   input  logic        push,
   input  logic        pop,
   input  logic [31:0] pc_in,
   input  logic [15:0] reg_in,
   input  logic [15:0] mem_rdata,
   output logic [31:0] mem_addr,
   output logic [15:0] mem_wdata,
   output logic        mem_we,
   output logic        mem_re,
   output logic [31:0] sp,
   output logic [31:0] pc_out,
   output logic        pc_valid,
   output logic [15:0] reg_out,
   output logic        reg_valid,
   output logic        busy,
   output logic        stack_err,
   output logic [3:0]  state_dbg
);

   // Request/busy contract: requests are sampled only on an edge where busy is low;
   // while busy is high they are ignored and the pipeline must hold them stalled.
   typedef enum logic [3:0] {
      IDLE, PSH1, PSH2, POP1, POP2, POP3, PSHW, POPW1, POPW2
   } state_t;

`ifdef STACK_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif

   state_t      state, nxt;
   logic [31:0] pc_q;
   logic [15:0] wd_q;
   logic [15:0] lo_q;
   logic        err_nxt;
   logic [31:0] sp_p1, sp_m1, sp_p2;
   logic        rej_pc_push, rej_w_push, rej_pc_pop, rej_w_pop;

   assign sp_p1 = sp + 32'd1;
   assign sp_m1 = sp - 32'd1;
   assign sp_p2 = sp + 32'd2;

   assign rej_pc_push = GUARD && (sp_m1 < STACK_LIMIT);
   assign rej_w_push  = GUARD && (sp < STACK_LIMIT);
   assign rej_pc_pop  = GUARD && (sp_p2 > SP_RESET);
   assign rej_w_pop   = GUARD && (sp_p1 > SP_RESET);

   assign busy      = (state != IDLE);
   assign state_dbg = state;

   always_comb begin
      nxt       = state;
      mem_addr  = 32'd0;
      mem_wdata = 16'd0;
      mem_we    = 1'b0;
      mem_re    = 1'b0;
      err_nxt   = 1'b0;
      case (state)
         IDLE: begin
            // Priority int > ret > call > pop > push; only the winner is checked.
            if (intr || (!ret && call)) begin
               if (rej_pc_push) err_nxt = 1'b1;
               else             nxt = PSH1;
            end else if (ret) begin
               if (rej_pc_pop) err_nxt = 1'b1;
               else            nxt = POP1;
            end else if (pop) begin
               if (rej_w_pop) err_nxt = 1'b1;
               else           nxt = POPW1;
            end else if (push) begin
               if (rej_w_push) err_nxt = 1'b1;
               else            nxt = PSHW;
            end
         end
         PSH1: begin
            mem_addr = sp; mem_wdata = pc_q[31:16]; mem_we = 1'b1; nxt = PSH2;
         end
         PSH2: begin
            mem_addr = sp; mem_wdata = pc_q[15:0]; mem_we = 1'b1; nxt = IDLE;
         end
         POP1: begin
            mem_addr = sp_p1; mem_re = 1'b1; nxt = POP2;
         end
         POP2: begin
            mem_addr = sp_p1; mem_re = 1'b1; nxt = POP3;
         end
         POP3:  nxt = IDLE;
         PSHW: begin
            mem_addr = sp; mem_wdata = wd_q; mem_we = 1'b1; nxt = IDLE;
         end
         POPW1: begin
            mem_addr = sp_p1; mem_re = 1'b1; nxt = POPW2;
         end
         POPW2: nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         sp        <= SP_RESET;
         pc_q      <= 32'd0;
         wd_q      <= 16'd0;
         lo_q      <= 16'd0;
         pc_out    <= 32'd0;
         pc_valid  <= 1'b0;
         reg_out   <= 16'd0;
         reg_valid <= 1'b0;
         stack_err <= 1'b0;
      end else begin
         state     <= nxt;
         pc_valid  <= (state == POP3);
         reg_valid <= (state == POPW2);
         stack_err <= err_nxt;
         if (state == IDLE && nxt == PSH1) pc_q <= pc_in;
         if (state == IDLE && nxt == PSHW) wd_q <= reg_in;
         case (state)
            PSH1, PSH2, PSHW:  sp <= sp_m1;
            POP1, POP2, POPW1: sp <= sp_p1;
            default: ;
         endcase
         // Read data arrives one cycle after the strobe: low half in POP2, high in POP3.
         if (state == POP2)  lo_q    <= mem_rdata;
         if (state == POP3)  pc_out  <= {mem_rdata, lo_q};
         if (state == POPW2) reg_out <= mem_rdata;
      end
   end

endmodule
